// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and its consumers.
// Latency: n/a (wires only). Backpressure: none; the raster free-runs.
// Optional ports frame_cnt / bird_y_hold exist only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [9:0]  x_pix;
  logic [9:0]  y_pix;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;
  logic [31:0] bird_y_in;
  logic [31:0] bird_y_out;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic        bird_y_hold;
`endif

  // Timing generator side
  modport master (
    output pix_en, x_pix, y_pix, hsync, vsync, active, frame_start, bird_y_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output frame_cnt,
    input  bird_y_hold,
`endif
    input  bird_y_in
  );

  // Colour stage / HDMI wrapper / processor side
  modport slave (
    input  pix_en, x_pix, y_pix, hsync, vsync, active, frame_start, bird_y_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
    input  frame_cnt,
    output bird_y_hold,
`endif
    output bird_y_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (pix_en, x/y, syncs, active, frame_start) plus a vblank-latched bird_y shadow.
// Latency: all outputs registered; syncs/active/frame_start change on the same edge as x/y (zero skew).
// Backpressure: none, free-running. Optional VGA_TIMING_FRAME_CNT_EN adds frame_cnt and bird_y_hold.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input logic              clock,
  input logic              rst,
  vga_timing_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit thresholds so a 1024-wide total or sync end never truncates to 0
  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end

  logic [3:0]  div_q, div_d;
  logic        pix_en_q, pix_en_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic [31:0] bird_y_q, bird_y_d;
  logic        line_end, vblank_start, capture;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  // Next-state: divider, raster counters and the outputs derived from the next counts
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    // pix_en trails the divider by one edge, so the first enable lands on
    // release edge CLK_DIV and CLK_DIV=1 gives a constant 1 after release.
    pix_en_d = (div_q == DIV_LAST);
    x_d      = x_q;
    y_d      = y_q;
    line_end = (x_q == X_LAST);
    if (pix_en_q) begin
      if (line_end) begin
        x_d = 10'd0;
        y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d       = !(({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END));
    vsync_d       = !(({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END));
    active_d      = ({1'b0, x_d} < X_ACT) && ({1'b0, y_d} < Y_ACT);
    frame_start_d = pix_en_q && line_end && (y_q == Y_LAST);
    vblank_start  = pix_en_q && line_end && (y_q == Y_ACT_END);
`ifdef VGA_TIMING_FRAME_CNT_EN
    capture       = vblank_start && !vif.bird_y_hold;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`else
    capture       = vblank_start;
`endif
    bird_y_d      = capture ? vif.bird_y_in : bird_y_q;
  end

  // State registers; reset parks the raster at (0,0) with syncs idle high
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      div_q         <= 4'd0;
      pix_en_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b1;
      frame_start_q <= 1'b0;
      bird_y_q      <= 32'd0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= 16'd0;
`endif
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      bird_y_q      <= bird_y_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign vif.pix_en      = pix_en_q;
  assign vif.x_pix       = x_q;
  assign vif.y_pix       = y_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.active      = active_q;
  assign vif.frame_start = frame_start_q;
  assign vif.bird_y_out  = bird_y_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign vif.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the raster generator on a shrunk 32x20 raster, CLK_DIV=4.
// hsync low x=20..25, vsync low y=14..15, vblank at y=12, one frame = 32*20*4 = 2560 clocks.
// Outputs are sampled on the falling edge.
module tb_vga_timing_gen;
  localparam int CD = 4;
  localparam int HT = 32;
  localparam int VT = 20;

  logic clock = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .vif   (vif.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the first falling edge showing (x,y); bounded
  task automatic wait_xy(input string tag, input int x, input int y);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      @(negedge clock);
      if (vif.x_pix == 10'(x) && vif.y_pix == 10'(y)) hit = 1'b1;
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pix_en"}, 32'(vif.pix_en), 32'd0);
    check({tag, "_x"}, 32'(vif.x_pix), 32'd0);
    check({tag, "_y"}, 32'(vif.y_pix), 32'd0);
    check({tag, "_hsync"}, 32'(vif.hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vif.vsync), 32'd1);
    check({tag, "_active"}, 32'(vif.active), 32'd1);
    check({tag, "_fstart"}, 32'(vif.frame_start), 32'd0);
    check({tag, "_bird"}, vif.bird_y_out, 32'd0);
  endtask

  initial begin
    int fs_clks, fs_x, fs_y, vs_clks, vs_ymin, vs_ymax, first_fs;
    logic done;

    rst = 1'b1;
    vif.bird_y_in = 32'd0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    vif.bird_y_hold = 1'b0;
`endif
    #1 rst = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rst_fcnt", 32'(vif.frame_cnt), 32'd0);
`endif

    // Release: pix_en first seen after release edge 4, x=1 after edge 5
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check($sformatf("pix_en_k%0d", k), 32'(vif.pix_en), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    check("x_after_en", 32'(vif.x_pix), 32'd1);
    check("pix_en_k5", 32'(vif.pix_en), 32'd0);
    check("hsync_x1", 32'(vif.hsync), 32'd1);
    check("active_x1", 32'(vif.active), 32'd1);

    // One line: active/hsync edges coincide with the counter change
    wait_xy("x15", 15, 0);
    check("active_x15", 32'(vif.active), 32'd1);
    wait_xy("x16", 16, 0);
    check("active_x16", 32'(vif.active), 32'd0);
    wait_xy("x19", 19, 0);
    check("hsync_x19", 32'(vif.hsync), 32'd1);
    wait_xy("x20", 20, 0);
    check("hsync_x20", 32'(vif.hsync), 32'd0);
    wait_xy("x25", 25, 0);
    check("hsync_x25", 32'(vif.hsync), 32'd0);
    wait_xy("x26", 26, 0);
    check("hsync_x26", 32'(vif.hsync), 32'd1);
    wait_xy("x31", 31, 0);
    repeat (3) @(negedge clock);
    check("x31_hold", 32'(vif.x_pix), 32'd31);
    @(negedge clock);
    check("wrap_x", 32'(vif.x_pix), 32'd0);
    check("wrap_y", 32'(vif.y_pix), 32'd1);
    check("wrap_active", 32'(vif.active), 32'd1);

    // Rest of the frame through to (1,0) of the next one
    fs_clks = 0; fs_x = -1; fs_y = -1; vs_clks = 0; vs_ymin = 99; vs_ymax = -1;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clock);
      if (vif.frame_start) begin
        fs_clks++; fs_x = int'(vif.x_pix); fs_y = int'(vif.y_pix);
      end
      if (!vif.vsync) begin
        vs_clks++;
        if (int'(vif.y_pix) < vs_ymin) vs_ymin = int'(vif.y_pix);
        if (int'(vif.y_pix) > vs_ymax) vs_ymax = int'(vif.y_pix);
      end
      if (vif.x_pix == 10'd1 && vif.y_pix == 10'd0) done = 1'b1;
    end
    check("frame_reached", 32'(done), 32'd1);
    check("fs_clks", 32'(fs_clks), 32'd1);
    check("fs_x", 32'(fs_x), 32'd0);
    check("fs_y", 32'(fs_y), 32'd0);
    check("vs_clks", 32'(vs_clks), 32'(2 * HT * CD));
    check("vs_ymin", 32'(vs_ymin), 32'd14);
    check("vs_ymax", 32'(vs_ymax), 32'd15);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_1", 32'(vif.frame_cnt), 32'd1);
`endif

    // Shadow register: only the value present at vblank start is shown
    wait_xy("y3", 0, 3);
    vif.bird_y_in = 32'h1234;
    wait_xy("y7", 0, 7);
    vif.bird_y_in = 32'h5678;
    wait_xy("y11", 31, 11);
    check("bird_pre_vb", vif.bird_y_out, 32'd0);
    wait_xy("y12", 0, 12);
    check("bird_vb1", vif.bird_y_out, 32'h5678);
    wait_xy("y2", 0, 2);
    vif.bird_y_in = 32'h9ABC;
    @(negedge clock);
    check("bird_hold_a", vif.bird_y_out, 32'h5678);
    wait_xy("y11b", 31, 11);
    check("bird_hold_b", vif.bird_y_out, 32'h5678);
    wait_xy("y12b", 0, 12);
    check("bird_vb2", vif.bird_y_out, 32'h9ABC);

    // Asynchronous reset mid-frame, held across 3 rising edges
    wait_xy("mid", 10, 5);
    #2 rst = 1'b0;
    #1 check_reset_vals("mid_rst");
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("mid_rst_x", 32'(vif.x_pix), 32'd0);
    rst = 1'b1;
    first_fs = 0; fs_clks = 0;
    for (int k = 1; k <= 2570; k++) begin
      @(negedge clock);
      if (k == 1) check("restart_xy", {12'd0, vif.y_pix, vif.x_pix}, 32'd0);
      if (k == 5) check("restart_x1", 32'(vif.x_pix), 32'd1);
      if (vif.frame_start) begin
        fs_clks++;
        if (first_fs == 0) first_fs = k;
      end
    end
    check("restart_fs_at", 32'(first_fs), 32'(HT * VT * CD + 1));
    check("restart_fs_cnt", 32'(fs_clks), 32'd1);
    check("restart_bird", vif.bird_y_out, 32'h9ABC);

`ifdef VGA_TIMING_FRAME_CNT_EN
    wait_xy("f2", 0, 0);
    wait_xy("f3", 0, 0);
    check("fcnt_3", 32'(vif.frame_cnt), 32'd3);
    vif.bird_y_hold = 1'b1;
    vif.bird_y_in = 32'hAAAA;
    wait_xy("hold_vb", 0, 12);
    check("bird_frozen", vif.bird_y_out, 32'h9ABC);
    wait_xy("hold_rel", 0, 13);
    vif.bird_y_hold = 1'b0;
    wait_xy("rel_vb", 0, 12);
    check("bird_after_hold", vif.bird_y_out, 32'hAAAA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
